// File: rtl/sipo_stream_if.sv
// Stream bundle for the serial-in/parallel-out assembler.
// The slave modport is the assembler itself. The master modport is whoever
// feeds elements in and drains frames out.
interface sipo_stream_if #(
    parameter int width_p = 8,
    parameter int depth_p = 8
);
    localparam int count_w_lp = $clog2(depth_p + 1);

    // input element side
    logic                          valid_i;
    logic                          ready_o;
    logic [width_p-1:0]            data_i;
    logic                          last_i;

    // assembled frame side
    logic                          valid_o;
    logic                          ready_i;
    logic [width_p*depth_p-1:0]    data_o;
    logic [count_w_lp-1:0]         count_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out assembler. Narrow elements are packed into one wide
// frame of up to depth_p slots. A frame closes when the last slot fills or when
// last_i arrives with an accepted element. The frame is then held with valid_o
// until downstream takes it. A new first element can be taken in the same cycle
// the old frame retires, so one element per cycle is sustained.
module sipo_stream #(
    parameter int width_p        = 8,
    parameter int depth_p        = 8,
    parameter bit first_at_msb_p = 1'b0
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    sipo_stream_if.slave bus
);

    localparam int idx_w_lp   = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int count_w_lp = $clog2(depth_p + 1);
    localparam int frame_w_lp = width_p * depth_p;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(depth_p - 1);

    if (width_p < 1 || depth_p < 1) begin : g_bad_params
        $error("sipo_stream: width_p and depth_p must both be at least 1");
    end

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [idx_w_lp-1:0]     idx_q, idx_d;
    logic [frame_w_lp-1:0]   buf_q, buf_d;
    logic [count_w_lp-1:0]   count_q, count_d;

    logic ready;
    logic acc;
    logic closes;

    // Returns the frame with element number k written into its slot. The slot
    // order is mirrored when the first element belongs at the top of the frame.
    function automatic logic [frame_w_lp-1:0] place(
        input logic [frame_w_lp-1:0] frame,
        input logic [idx_w_lp-1:0]   k,
        input logic [width_p-1:0]    elem
    );
        logic [frame_w_lp-1:0] result;
        int                    slot;
        result = frame;
        slot   = first_at_msb_p ? (depth_p - 1 - int'(k)) : int'(k);
        for (int s = 0; s < depth_p; s++) begin
            if (s == slot) begin
                result[s*width_p +: width_p] = elem;
            end
        end
        return result;
    endfunction

    // Input is taken while filling, or while holding if the held frame leaves
    // in this same cycle. Input is never taken during reset.
    always_comb begin
        ready  = reset_ni & ((state_q == FILL) | bus.ready_i);
        acc    = bus.valid_i & ready;
        closes = bus.last_i | (idx_q == last_idx_lp);
    end

    // Next-state logic for the fill/hold controller and the frame buffer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (acc) begin
                    buf_d = place(buf_q, idx_q, bus.data_i);
                    if (closes) begin
                        state_d = HOLD;
                        count_d = count_w_lp'(idx_q) + count_w_lp'(1);
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + idx_w_lp'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.ready_i) begin
                    state_d = FILL;
                    idx_d   = '0;
                    buf_d   = '0;
                    count_d = '0;
                    if (acc) begin
                        buf_d = place('0, '0, bus.data_i);
                        if (closes) begin
                            state_d = HOLD;
                            count_d = count_w_lp'(1);
                        end else begin
                            idx_d = idx_w_lp'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                buf_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // State, slot index, frame buffer and element count registers. A reset
    // throws away any partial or held frame.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= FILL;
            idx_q   <= '0;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    // The held frame is presented straight from the registers.
    always_comb begin
        bus.ready_o = ready;
        bus.valid_o = (state_q == HOLD);
        bus.data_o  = buf_q;
        bus.count_o = count_q;
    end

endmodule
